// File: rtl/cle_engine.sv
// cle_engine: two-pass connected-component labeler for a 32x32 binary image.
//
// Pass 1 raster-scans the image from ROM, assigns provisional labels from the
// already-scanned neighbours and writes them to SRAM. Equivalences are folded
// into a class map as they are discovered, so every provisional label always
// maps to the smallest label of its class. Pass 2 reads each SRAM word back
// and rewrites it with its resolved label.
//
// Build option: define CLE_CONN8_EN for 8-connectivity (left, up-left, up,
// up-right); the default build uses 4-connectivity (left, up).
//
// Ports:
//   clk       system clock, rising edge
//   reset     asynchronous active-high reset
//   rom_q     image ROM data, valid one cycle after rom_a is sampled
//   rom_a     image ROM address (128 x 8, byte r*4+c/8, bit 7 = leftmost pixel)
//   sram_q    label SRAM read data, valid one cycle after sram_a is sampled
//   sram_a    label SRAM address (1024 x 8, word r*32+c)
//   sram_d    label SRAM write data
//   sram_wen  label SRAM write enable, active low
//   finish    high once the labeled image is complete in SRAM
module cle_engine #(
  parameter int unsigned MAX_LABELS = 63
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] rom_q,
  output logic [6:0] rom_a,
  input  logic [7:0] sram_q,
  output logic [9:0] sram_a,
  output logic [7:0] sram_d,
  output logic       sram_wen,
  output logic       finish
);

`ifdef CLE_CONN8_EN
  localparam bit Conn8 = 1'b1;
`else
  localparam bit Conn8 = 1'b0;
`endif

  localparam logic [2:0] StIdle    = 3'd0;
  localparam logic [2:0] StP1Fetch = 3'd1;
  localparam logic [2:0] StP1Label = 3'd2;
  localparam logic [2:0] StResolve = 3'd3;
  localparam logic [2:0] StP2Read  = 3'd4;
  localparam logic [2:0] StP2Write = 3'd5;
  localparam logic [2:0] StDone    = 3'd6;

  localparam logic [7:0] MaxLbl = 8'(MAX_LABELS);

  logic [2:0] state_q, state_d;
  logic [9:0] idx_q, idx_d;          // pixel index {row, col}
  logic [8:0] next_q, next_d;        // next fresh provisional label
  logic [7:0] left_q, left_d;        // label of the previous pixel in this row
  logic [7:0] up_left_q, up_left_d;  // previous-row label at col-1 (line buffer already overwritten)
  logic [7:0] line_q [32];
  logic [7:0] line_d [32];
  logic [7:0] map_q [MAX_LABELS+1];  // provisional label -> smallest label of its class
  logic [7:0] map_d [MAX_LABELS+1];

  logic [4:0] col;
  logic       pix;
  logic       any_nb;
  logic [7:0] nb [4];
  logic [7:0] cls [4];
  logic [7:0] nb_min, cls_min, new_lbl, lbl, p2_lbl;

  assign col   = idx_q[4:0];
  assign pix   = rom_q[3'd7 - idx_q[2:0]];
  assign rom_a = idx_q[9:3];
  assign sram_a = idx_q;

  // Neighbour labels, their classes and the label for the current pixel.
  always_comb begin
    nb[0] = (col != 5'd0) ? left_q : 8'd0;
    nb[1] = (Conn8 && col != 5'd0) ? up_left_q : 8'd0;
    nb[2] = line_q[col];
    nb[3] = (Conn8 && col != 5'd31) ? line_q[col + 5'd1] : 8'd0;
    any_nb  = 1'b0;
    nb_min  = 8'hff;
    cls_min = 8'hff;
    for (int k = 0; k < 4; k++) begin
      cls[k] = 8'd0;
      for (int unsigned i = 1; i <= MAX_LABELS; i++) begin
        if (nb[k] == 8'(i)) cls[k] = map_q[i];
      end
      if (nb[k] != 8'd0) begin
        any_nb = 1'b1;
        if (nb[k] < nb_min) nb_min = nb[k];
        if (cls[k] < cls_min) cls_min = cls[k];
      end
    end
    // Past capacity every new object collapses onto the last label.
    new_lbl = (next_q > 9'(MAX_LABELS)) ? MaxLbl : next_q[7:0];
    lbl     = !pix ? 8'd0 : (any_nb ? nb_min : new_lbl);
    p2_lbl  = 8'd0;
    for (int unsigned i = 0; i <= MAX_LABELS; i++) begin
      if (sram_q == 8'(i)) p2_lbl = map_q[i];
    end
  end

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    next_d    = next_q;
    left_d    = left_q;
    up_left_d = up_left_q;
    line_d    = line_q;
    map_d     = map_q;
    case (state_q)
      StIdle:    state_d = StP1Fetch;
      StP1Fetch: state_d = StP1Label;
      StP1Label: begin
        line_d[col] = lbl;
        left_d      = lbl;
        up_left_d   = line_q[col];
        if (pix && !any_nb && next_q <= 9'(MAX_LABELS)) next_d = next_q + 9'd1;
        for (int unsigned i = 1; i <= MAX_LABELS; i++) begin
          if (pix && !any_nb && next_q <= 9'(MAX_LABELS) && new_lbl == 8'(i)) begin
            map_d[i] = 8'(i);
          end else if (pix && any_nb && map_q[i] != 8'd0 &&
                       (map_q[i] == cls[0] || map_q[i] == cls[1] ||
                        map_q[i] == cls[2] || map_q[i] == cls[3])) begin
            // Merge every touching class into the smallest one.
            map_d[i] = cls_min;
          end
        end
        idx_d   = idx_q + 10'd1;
        state_d = (idx_q == 10'd1023) ? StResolve : StP1Fetch;
      end
      // Classes are merged eagerly, so the map is already resolved here.
      StResolve: state_d = StP2Read;
      StP2Read:  state_d = StP2Write;
      StP2Write: begin
        idx_d   = idx_q + 10'd1;
        state_d = (idx_q == 10'd1023) ? StDone : StP2Read;
      end
      StDone:  state_d = StDone;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    sram_wen = 1'b1;
    sram_d   = 8'd0;
    finish   = 1'b0;
    case (state_q)
      StP1Label: begin
        sram_wen = 1'b0;
        sram_d   = lbl;
      end
      StP2Write: begin
        sram_wen = 1'b0;
        sram_d   = p2_lbl;
      end
      StDone:  finish = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= StIdle;
      idx_q     <= 10'd0;
      next_q    <= 9'd1;
      left_q    <= 8'd0;
      up_left_q <= 8'd0;
      line_q    <= '{default: '0};
      map_q     <= '{default: '0};
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      next_q    <= next_d;
      left_q    <= left_d;
      up_left_q <= up_left_d;
      line_q    <= line_d;
      map_q     <= map_d;
    end
  end

endmodule

// File: tb/tb_cle_engine.sv
// Bench for cle_engine: behavioural ROM/SRAM models, flood-fill reference
// labeling, directed images plus random rectangle images.
module tb_cle_engine;

  localparam int unsigned MaxLabels = 63;
`ifdef CLE_CONN8_EN
  localparam bit Conn8 = 1'b1;
`else
  localparam bit Conn8 = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] rom_q;
  logic [6:0] rom_a;
  logic [7:0] sram_q;
  logic [9:0] sram_a;
  logic [7:0] sram_d;
  logic       sram_wen;
  logic       finish;

  logic [7:0] rom [128];
  logic [7:0] sram [1024];
  int         wcnt [1024];
  int         comp [1024];
  int         total = 0;
  int         bad = 0;

  cle_engine #(.MAX_LABELS(MaxLabels)) dut (
    .clk(clk),
    .reset(reset),
    .rom_q(rom_q),
    .rom_a(rom_a),
    .sram_q(sram_q),
    .sram_a(sram_a),
    .sram_d(sram_d),
    .sram_wen(sram_wen),
    .finish(finish)
  );

  always #5 clk = ~clk;

  always @(posedge clk) rom_q <= rom[rom_a];

  // SRAM is filled with an out-of-range pattern on reset so skipped writes show up.
  always @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 1024; i++) begin
        sram[i] <= 8'hee;
        wcnt[i] <= 0;
      end
    end else if (!sram_wen) begin
      sram[sram_a] <= sram_d;
      wcnt[sram_a] <= wcnt[sram_a] + 1;
    end
    sram_q <= sram[sram_a];
  end

  task automatic chk(string tag, int obs, int exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic clear_img();
    for (int i = 0; i < 128; i++) rom[i] = 8'h00;
  endtask

  task automatic set_px(int r, int c);
    rom[r*4 + c/8] = rom[r*4 + c/8] | (8'h80 >> (c % 8));
  endtask

  task automatic set_rect(int r0, int c0, int h, int w);
    for (int r = r0; r < r0 + h; r++)
      for (int c = c0; c < c0 + w; c++)
        if (r < 32 && c < 32) set_px(r, c);
  endtask

  function automatic bit px(int r, int c);
    return rom[r*4 + c/8][7 - (c % 8)];
  endfunction

  // Flood fill; components are numbered in raster order of their first pixel.
  task automatic build_ref(output int ncomp);
    int q[$];
    int id;
    int cur;
    id = 0;
    for (int i = 0; i < 1024; i++) comp[i] = 0;
    for (int p = 0; p < 1024; p++) begin
      if (px(p / 32, p % 32) && comp[p] == 0) begin
        id++;
        comp[p] = id;
        q.push_back(p);
        while (q.size() > 0) begin
          cur = q.pop_front();
          for (int dr = -1; dr <= 1; dr++) begin
            for (int dc = -1; dc <= 1; dc++) begin
              int nr;
              int nc;
              nr = cur / 32 + dr;
              nc = cur % 32 + dc;
              if ((dr != 0 || dc != 0) && (Conn8 || dr == 0 || dc == 0) &&
                  nr >= 0 && nr < 32 && nc >= 0 && nc < 32) begin
                if (px(nr, nc) && comp[nr*32 + nc] == 0) begin
                  comp[nr*32 + nc] = id;
                  q.push_back(nr*32 + nc);
                end
              end
            end
          end
        end
      end
    end
    ncomp = id;
  endtask

  task automatic start_run();
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic finish_and_check(string tag);
    int cyc;
    int n;
    int e_bg, e_rng, e_uni, e_ord, e_wr, e_hold;
    int rep [1025];
    bit seen [1025];
    cyc = 0;
    e_bg = 0; e_rng = 0; e_uni = 0; e_ord = 0; e_wr = 0; e_hold = 0;
    while (finish !== 1'b1 && cyc < 10000) begin
      @(negedge clk);
      cyc++;
    end
    chk({tag, ".finish"}, int'(finish === 1'b1), 1);
    build_ref(n);
    for (int k = 0; k <= 1024; k++) begin
      rep[k] = 0;
      seen[k] = 1'b0;
    end
    for (int p = 0; p < 1024; p++) begin
      if (comp[p] != 0 && !seen[comp[p]]) begin
        seen[comp[p]] = 1'b1;
        rep[comp[p]] = int'(sram[p]);
      end
    end
    for (int p = 0; p < 1024; p++) begin
      if ((comp[p] == 0) != (sram[p] == 8'd0)) e_bg++;
      if (comp[p] != 0 && int'(sram[p]) > int'(MaxLabels)) e_rng++;
      if (comp[p] != 0 && int'(sram[p]) != rep[comp[p]]) e_uni++;
      if (wcnt[p] != 2) e_wr++;
    end
    for (int k = 2; k <= n; k++) if (rep[k] <= rep[k-1]) e_ord++;
    chk({tag, ".background"}, e_bg, 0);
    chk({tag, ".range"}, e_rng, 0);
    chk({tag, ".uniform"}, e_uni, 0);
    chk({tag, ".distinct_order"}, e_ord, 0);
    chk({tag, ".writes"}, e_wr, 0);
    if (n > 0) chk({tag, ".first_label"}, rep[1], 1);
    repeat (16) begin
      @(negedge clk);
      if (finish !== 1'b1 || sram_wen !== 1'b1) e_hold++;
    end
    chk({tag, ".hold"}, e_hold, 0);
  endtask

  initial begin
    int nrect;

    // All-zero image.
    clear_img();
    start_run();
    chk("rst.finish_low", int'(finish), 0);
    finish_and_check("zero");

    // Single pixel at (0,0).
    clear_img();
    rom[0] = 8'h80;
    start_run();
    finish_and_check("single");
    chk("single.px00_nonzero", int'(sram[0] != 8'd0), 1);

    // Diagonal pair (0,1) and (1,0).
    clear_img();
    set_px(0, 1);
    set_px(1, 0);
    start_run();
    finish_and_check("diag");
    chk("diag.shared", int'(sram[1] == sram[32]), Conn8 ? 1 : 0);

    // U shape.
    clear_img();
    set_rect(0, 2, 5, 1);
    set_rect(0, 6, 5, 1);
    set_rect(4, 2, 1, 5);
    start_run();
    finish_and_check("ushape");
    chk("ushape.arms", int'(sram[2] == sram[6]), 1);

    // Five disjoint 3x3 blocks.
    clear_img();
    set_rect(1, 1, 3, 3);
    set_rect(1, 10, 3, 3);
    set_rect(1, 20, 3, 3);
    set_rect(10, 5, 3, 3);
    set_rect(20, 25, 3, 3);
    start_run();
    finish_and_check("blocks");
    chk("blocks.last", int'(sram[20*32 + 25]), 5);

    // Reset pulsed during pass 2, same image.
    start_run();
    repeat (3000) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("midrst.rom_a", int'(rom_a), 0);
    chk("midrst.sram_a", int'(sram_a), 0);
    chk("midrst.sram_d", int'(sram_d), 0);
    chk("midrst.sram_wen", int'(sram_wen), 1);
    chk("midrst.finish", int'(finish), 0);
    @(negedge clk);
    reset = 1'b0;
    finish_and_check("midrst");

    // Random rectangle images; each rectangle adds at most one fresh label.
    for (int t = 0; t < 3; t++) begin
      clear_img();
      nrect = int'($urandom_range(3, 6));
      for (int k = 0; k < nrect; k++) begin
        set_rect(int'($urandom_range(0, 31)), int'($urandom_range(0, 31)),
                 int'($urandom_range(1, 5)), int'($urandom_range(1, 5)));
      end
      start_run();
      finish_and_check($sformatf("rand%0d", t));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
